dmem_port_arbiter: RTL and testbench
====================================

// Module: dmem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous memory between two requesters:
//  - instruction fetch (IF): read-only
//  - load/store unit (LS): read or write
//  Sits between the core's fetch/LSU logic and the memory macro.
//  Sequences each access through issue / wait / ack states with fixed latency.
//  LS has priority; a streak counter guarantees IF forward progress.
// PARAMETERS
//  ADDR_W         5   memory word-address width (32-word memory)
//  DATA_W         32  data width
//  MEM_LAT        1   cycles from mem_en high to valid mem_rdata (>=1)
//  MAX_LS_STREAK  4   max consecutive LS grants while if_req is pending (>=1)
// PORTS
//  clk        in   1       rising-edge clock
//  reset      in   1       synchronous, active-high reset
//  if_req     in   1       IF access request; held with if_addr until if_ack
//  if_addr    in   ADDR_W  IF word address
//  if_ack     out  1       1-cycle pulse: IF access done, if_rdata valid
//  if_rdata   out  DATA_W  IF read data (registered, holds until next IF ack)
//  ls_req     in   1       LS request; held with ls_we/addr/wdata until ls_ack
//  ls_we      in   1       1 = write, 0 = read
//  ls_addr    in   ADDR_W  LS word address
//  ls_wdata   in   DATA_W  LS write data
//  ls_ack     out  1       1-cycle pulse: LS access done
//  ls_rdata   out  DATA_W  LS read data (updated on read acks only)
//  mem_en     out  1       memory access strobe, high exactly 1 cycle per access
//  mem_we     out  1       memory write enable (qualified by mem_en)
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid MEM_LAT cycles after mem_en
//  busy       out  1       high in every state except IDLE
// BEHAVIOUR
//  Reset values:
//  - All outputs, if_rdata/ls_rdata and the streak counter are 0; state = IDLE.
//  - Reset mid-access aborts it: no ack, outputs 0 on the next cycle.
//  - A write whose mem_en cycle coincides with reset is still taken by memory.
//  - Requesters re-issue aborted accesses.
//  All mem_* outputs and acks are registered.
//  FSM: IDLE -> ISSUE -> WAIT -> ACK -> IDLE.
//  - IDLE: if no req, stay. Otherwise arbitrate (below), latch winner's
//    we/addr/wdata (IF: we=0), go to ISSUE.
//  - ISSUE (1 cycle): mem_en=1 with latched we/addr/wdata. Wait counter loaded
//    with MEM_LAT-1. Go to WAIT, or directly to capture if MEM_LAT=1.
//  - WAIT: count down. In the cycle mem_rdata is valid (MEM_LAT cycles after
//    ISSUE), capture into the winner's rdata register (reads only), go to ACK.
//  - ACK (1 cycle): pulse winner's ack. Go to IDLE.
//  Latency: req first seen in IDLE at cycle T -> mem_en at T+1 -> ack at
//  T+2+MEM_LAT. Reads and writes take the same time.
//  Max throughput: 1 access per MEM_LAT+3 cycles. The requester drops or
//  changes its request in the cycle after ack; IDLE samples that cycle.
//  Arbitration (IDLE only, both requests high):
//  - LS wins unless streak == MAX_LS_STREAK, in which case IF wins.
//  Streak counter (width clog2(MAX_LS_STREAK+1), saturating):
//  - +1 on an LS grant while if_req=1.
//  - Cleared on any IF grant, or on an LS grant with if_req=0.
//  Request changes outside IDLE are ignored. Only one ack is high in any cycle.
// TESTING
//  1. IF-only read: mem[4]=0x00628E33, if_req=1 addr 4 at T -> mem_en=1,
//     we=0, addr=4 at T+1; if_ack=1 with if_rdata=0x00628E33 at T+3; busy
//     T+1..T+3.
//  2. Simultaneous requests at T: LS write addr 3 data 0xDEADBEEF, IF read
//     addr 0 -> mem_we=1 at T+1, ls_ack at T+3; IF mem_en at T+5, if_ack at T+7.
//  3. MAX_LS_STREAK=2, ls_req and if_req held continuously -> grant order
//     LS, LS, IF, LS, LS, IF; never 3 LS grants in a row.
//  4. Read-after-write: LS write 0x0000005A to addr 7, then LS read addr 7
//     -> ls_rdata=0x5A on the 2nd ls_ack; if_rdata unchanged.
//  5. MEM_LAT=3: IF read at T -> mem_en at T+1 only; if_ack at T+5.
//  6. MEM_LAT=3, reset at T+3 of an IF read -> from T+4 all outputs 0, no
//     if_ack; after release a new IF read completes normally with correct data.

Source files
------------

// File: rtl/dmem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter_if
// Request/response channel between one memory requester and the
// dmem_port_arbiter. The requester holds req together with we/addr/wdata until
// it sees the one-cycle ack; rdata is valid in the ack cycle and is held by
// the arbiter until that requester's next read ack.
//
// Signals
//   req    requester -> arbiter  access request
//   we     requester -> arbiter  1 = write, 0 = read
//   addr   requester -> arbiter  word address
//   wdata  requester -> arbiter  write data
//   ack    arbiter -> requester  one-cycle completion pulse
//   rdata  arbiter -> requester  read data
//
// Modports
//   master  requester side (fetch unit, load/store unit, testbench)
//   slave   arbiter side
// -----------------------------------------------------------------------------
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input  ack, rdata);
    modport slave  (input  req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_port_arbiter
// Shares one single-port synchronous memory between the instruction-fetch
// requester (read-only) and the load/store requester (read or write). Every
// access walks IDLE -> ISSUE -> WAIT -> ACK, so an access takes a fixed
// MEM_LAT+3 cycles from the cycle the request is sampled in IDLE to the cycle
// after its ack. LS normally wins a collision; a streak counter hands the
// memory to IF after MAX_LS_STREAK back-to-back LS grants that kept IF waiting.
//
// Parameters
//   ADDR_W         memory word-address width
//   DATA_W         data width
//   MEM_LAT        cycles from mem_en to valid mem_rdata (>= 1)
//   MAX_LS_STREAK  max consecutive LS grants while IF is waiting (>= 1)
//
// Ports
//   i_clk        rising-edge clock
//   i_reset      synchronous active-high reset
//   if_port      IF channel (we/wdata ignored, IF accesses are reads)
//   ls_port      LS channel
//   o_mem_en     memory strobe, exactly one cycle per access
//   o_mem_we     memory write enable, qualified by o_mem_en
//   o_mem_addr   memory word address
//   o_mem_wdata  memory write data
//   i_mem_rdata  memory read data, valid MEM_LAT cycles after o_mem_en
//   o_busy       high in every state except IDLE
// -----------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W        = 5,
    parameter int DATA_W        = 32,
    parameter int MEM_LAT       = 1,
    parameter int MAX_LS_STREAK = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    dmem_port_arbiter_if.slave  if_port,
    dmem_port_arbiter_if.slave  ls_port,
    output logic                o_mem_en,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    output logic                o_busy
);

    localparam int CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam int STREAK_W = $clog2(MAX_LS_STREAK + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [STREAK_W-1:0] r_streak;
    logic                r_win_ls;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_if_ack;
    logic                r_ls_ack;
    logic [DATA_W-1:0]   r_if_rdata;
    logic [DATA_W-1:0]   r_ls_rdata;
    logic                r_busy;

    logic                w_streak_full;
    logic                w_grant_ls;
    logic                w_any_req;
    logic [STREAK_W-1:0] w_streak_next;

    // IF only overrides LS once LS has been granted MAX_LS_STREAK times in a
    // row while IF was waiting; with IF idle, LS always wins.
    assign w_streak_full = (r_streak == STREAK_W'(MAX_LS_STREAK));
    assign w_grant_ls    = ls_port.req && !(if_port.req && w_streak_full);
    assign w_any_req     = ls_port.req || if_port.req;

    // The streak only grows while IF is actually being held off; any IF grant
    // or an uncontested LS grant restarts it.
    assign w_streak_next = (w_grant_ls && if_port.req)
                         ? (w_streak_full ? r_streak : r_streak + 1'b1)
                         : '0;

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_win_ls    <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_ack    <= 1'b0;
            r_ls_ack    <= 1'b0;
            // NOTE: the read-data holding registers are visible outputs, so
            // they are reset along with the control state.
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: one-cycle pulses default low here and are raised only in
            // the single state that owns them.
            r_mem_en <= 1'b0;
            r_if_ack <= 1'b0;
            r_ls_ack <= 1'b0;

            unique case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_state  <= ST_ISSUE;
                        r_busy   <= 1'b1;
                        r_mem_en <= 1'b1;
                        r_win_ls <= w_grant_ls;
                        r_streak <= w_streak_next;
                        if (w_grant_ls) begin
                            r_mem_we    <= ls_port.we;
                            r_mem_addr  <= ls_port.addr;
                            r_mem_wdata <= ls_port.wdata;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_addr  <= if_port.addr;
                        end
                    end
                end

                ST_ISSUE: begin
                    // Memory strobe is high during this cycle; rdata arrives
                    // after MEM_LAT-1 further WAIT cycles.
                    r_cnt   <= CNT_W'(MEM_LAT - 1);
                    r_state <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        // mem_we is still held from ISSUE, so it tells us
                        // whether this access returns data.
                        if (!r_mem_we) begin
                            if (r_win_ls) begin
                                r_ls_rdata <= i_mem_rdata;
                            end else begin
                                r_if_rdata <= i_mem_rdata;
                            end
                        end
                        r_if_ack <= !r_win_ls;
                        r_ls_ack <= r_win_ls;
                        r_state  <= ST_ACK;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end

                ST_ACK: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_mem_en      = r_mem_en;
    assign o_mem_we      = r_mem_we;
    assign o_mem_addr    = r_mem_addr;
    assign o_mem_wdata   = r_mem_wdata;
    assign o_busy        = r_busy;
    assign if_port.ack   = r_if_ack;
    assign if_port.rdata = r_if_rdata;
    assign ls_port.ack   = r_ls_ack;
    assign ls_port.rdata = r_ls_rdata;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_port_arbiter
// Directed bench for dmem_port_arbiter. Two instances share one clock:
//   dut_a  MEM_LAT=1, MAX_LS_STREAK=2
//   dut_b  MEM_LAT=3, MAX_LS_STREAK=4
// Each has its own behavioural memory with the matching read latency; read
// data outside the valid cycle is a poison pattern. Inputs are driven and
// outputs sampled 1 time unit after the rising edge; "cycle T+k" below means
// the k-th such sample after the cycle in which a request was raised.
// -----------------------------------------------------------------------------
module tb_dmem_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [DW-1:0] POISON = 32'hBAD0_BAD0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;

    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifa ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) lsa ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) ifb ();
    dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) lsb ();

    logic          a_en, a_we, busy_a;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata, a_rdata;
    logic          b_en, b_we, busy_b;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata, b_rdata;

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(1), .MAX_LS_STREAK(2)) dut_a (
        .i_clk(clk), .i_reset(rst_a), .if_port(ifa), .ls_port(lsa),
        .o_mem_en(a_en), .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata),
        .i_mem_rdata(a_rdata), .o_busy(busy_a)
    );

    dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(3), .MAX_LS_STREAK(4)) dut_b (
        .i_clk(clk), .i_reset(rst_b), .if_port(ifb), .ls_port(lsb),
        .o_mem_en(b_en), .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata),
        .i_mem_rdata(b_rdata), .o_busy(busy_b)
    );

    // Backdoor preload port shared by both memory models.
    logic          bd_en  = 1'b0;
    logic          bd_sel = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [DW-1:0] bd_data = '0;

    // Memory A: one-cycle read latency.
    logic [DW-1:0] mem_a [32];
    logic [DW-1:0] rd_a;
    logic          vld_a = 1'b0;
    always @(posedge clk) begin
        vld_a <= (a_en === 1'b1) && (a_we === 1'b0);
        rd_a  <= mem_a[a_addr];
        if ((a_en === 1'b1) && (a_we === 1'b1)) mem_a[a_addr] <= a_wdata;
        if (bd_en && !bd_sel) mem_a[bd_addr] <= bd_data;
    end
    assign a_rdata = vld_a ? rd_a : POISON;

    // Memory B: three-cycle read latency.
    logic [DW-1:0] mem_b [32];
    logic [DW-1:0] p_b [3];
    logic [2:0]    v_b = 3'b000;
    always @(posedge clk) begin
        v_b    <= {v_b[1:0], (b_en === 1'b1) && (b_we === 1'b0)};
        p_b[0] <= mem_b[b_addr];
        p_b[1] <= p_b[0];
        p_b[2] <= p_b[1];
        if ((b_en === 1'b1) && (b_we === 1'b1)) mem_b[b_addr] <= b_wdata;
        if (bd_en && bd_sel) mem_b[bd_addr] <= bd_data;
    end
    assign b_rdata = v_b[2] ? p_b[2] : POISON;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic sel, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        bd_en   = 1'b1;
        bd_sel  = sel;
        bd_addr = addr;
        bd_data = data;
        tick();
        bd_en   = 1'b0;
    endtask

    // One LS access on dut_a; returns in the ack cycle with the request dropped.
    task automatic ls_a(input string tag, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
        logic seen;
        seen      = 1'b0;
        lsa.req   = 1'b1;
        lsa.we    = we;
        lsa.addr  = addr;
        lsa.wdata = wd;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (lsa.ack === 1'b1) begin
                seen    = 1'b1;
                lsa.req = 1'b0;
                break;
            end
        end
        check({tag, " ack seen"}, seen, 1'b1);
    endtask

    logic exp_ls [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int seen_at;

        rst_a = 1'b1;
        rst_b = 1'b1;
        ifa.req = 1'b0; ifa.we = 1'b0; ifa.addr = '0; ifa.wdata = '0;
        lsa.req = 1'b0; lsa.we = 1'b0; lsa.addr = '0; lsa.wdata = '0;
        ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.wdata = '0;
        lsb.req = 1'b0; lsb.we = 1'b0; lsb.addr = '0; lsb.wdata = '0;
        tick();
        tick();

        preload(1'b0, 5'd4,  32'h0062_8E33);
        preload(1'b0, 5'd0,  32'h1111_1111);
        preload(1'b0, 5'd10, 32'hA0A0_A0A0);
        preload(1'b0, 5'd11, 32'hB1B1_B1B1);
        preload(1'b1, 5'd9,  32'hCAFE_F00D);
        preload(1'b1, 5'd2,  32'h2222_2222);

        // Reset state of both instances.
        check("rst a ctl", {ifa.ack, lsa.ack, a_en, a_we, a_addr, a_wdata, busy_a}, '0);
        check("rst a rdata", {ifa.rdata, lsa.rdata}, '0);
        check("rst b ctl", {ifb.ack, lsb.ack, b_en, b_we, b_addr, b_wdata, busy_b}, '0);
        check("rst b rdata", {ifb.rdata, lsb.rdata}, '0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        tick();

        // 1. IF-only read on dut_a.
        ifa.req  = 1'b1;
        ifa.addr = 5'd4;
        tick(); // T+1
        check("t1 mem_en", a_en, 1'b1);
        check("t1 mem_we", a_we, 1'b0);
        check("t1 mem_addr", a_addr, 5'd4);
        check("t1 busy T+1", busy_a, 1'b1);
        tick(); // T+2
        check("t1 mem_en T+2", a_en, 1'b0);
        check("t1 busy T+2", busy_a, 1'b1);
        check("t1 if_ack T+2", ifa.ack, 1'b0);
        tick(); // T+3
        check("t1 if_ack T+3", ifa.ack, 1'b1);
        check("t1 if_rdata", ifa.rdata, 32'h0062_8E33);
        check("t1 busy T+3", busy_a, 1'b1);
        check("t1 ls_ack T+3", lsa.ack, 1'b0);
        ifa.req = 1'b0;
        tick(); // T+4
        check("t1 if_ack T+4", ifa.ack, 1'b0);
        check("t1 busy T+4", busy_a, 1'b0);

        // 2. Simultaneous LS write and IF read: LS first, IF right after.
        lsa.req   = 1'b1;
        lsa.we    = 1'b1;
        lsa.addr  = 5'd3;
        lsa.wdata = 32'hDEAD_BEEF;
        ifa.req   = 1'b1;
        ifa.addr  = 5'd0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("t2 mem_en T+%0d", k), a_en, (k == 1) || (k == 5));
            check($sformatf("t2 ls_ack T+%0d", k), lsa.ack, k == 3);
            check($sformatf("t2 if_ack T+%0d", k), ifa.ack, k == 7);
            if (k == 1) begin
                check("t2 ls mem_we", a_we, 1'b1);
                check("t2 ls mem_wdata", a_wdata, 32'hDEAD_BEEF);
            end
            if (k == 5) begin
                check("t2 if mem_we", a_we, 1'b0);
                check("t2 if mem_addr", a_addr, 5'd0);
            end
            if (k == 3) lsa.req = 1'b0;
            if (k == 7) begin
                check("t2 if_rdata", ifa.rdata, 32'h1111_1111);
                ifa.req = 1'b0;
            end
        end
        check("t2 memory word 3", mem_a[3], 32'hDEAD_BEEF);

        // 4. Read-after-write through LS; a write ack leaves ls_rdata alone.
        ls_a("t4 write", 1'b1, 5'd7, 32'h0000_005A);
        check("t4 ls_rdata after write", lsa.rdata, 32'h0);
        ls_a("t4 read", 1'b0, 5'd7, 32'h0);
        check("t4 ls_rdata after read", lsa.rdata, 32'h0000_005A);
        check("t4 if_rdata unchanged", ifa.rdata, 32'h1111_1111);

        // 3. Both requesters held high: LS, LS, IF, LS, LS, IF.
        lsa.req  = 1'b1;
        lsa.we   = 1'b0;
        lsa.addr = 5'd10;
        ifa.req  = 1'b1;
        ifa.addr = 5'd11;
        g = 0;
        for (int c = 0; c < 60 && g < 6; c++) begin
            tick();
            check("t3 acks exclusive", lsa.ack & ifa.ack, 1'b0);
            if (lsa.ack || ifa.ack) begin
                check($sformatf("t3 grant %0d is LS", g), lsa.ack, exp_ls[g]);
                if (lsa.ack) check($sformatf("t3 grant %0d ls_rdata", g), lsa.rdata, 32'hA0A0_A0A0);
                else         check($sformatf("t3 grant %0d if_rdata", g), ifa.rdata, 32'hB1B1_B1B1);
                g++;
            end
        end
        check("t3 grants observed", g, 6);
        lsa.req = 1'b0;
        ifa.req = 1'b0;
        tick();

        // 5. MEM_LAT=3 IF read on dut_b.
        ifb.req  = 1'b1;
        ifb.addr = 5'd9;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("t5 mem_en T+%0d", k), b_en, k == 1);
            check($sformatf("t5 if_ack T+%0d", k), ifb.ack, k == 5);
            check($sformatf("t5 busy T+%0d", k), busy_b, k <= 5);
            if (k == 5) begin
                check("t5 if_rdata", ifb.rdata, 32'hCAFE_F00D);
                ifb.req = 1'b0;
            end
        end

        // 6. Reset in the middle of a MEM_LAT=3 read, then a clean re-issue.
        ifb.req  = 1'b1;
        ifb.addr = 5'd2;
        tick(); // T+1
        check("t6 mem_en T+1", b_en, 1'b1);
        tick(); // T+2
        tick(); // T+3
        check("t6 busy T+3", busy_b, 1'b1);
        check("t6 if_ack T+3", ifb.ack, 1'b0);
        rst_b = 1'b1;
        tick(); // T+4
        check("t6 ctl after reset", {ifb.ack, lsb.ack, b_en, b_we, b_addr, b_wdata, busy_b}, '0);
        check("t6 if_rdata after reset", ifb.rdata, 32'h0);
        rst_b = 1'b0;
        seen_at = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ifb.ack === 1'b1) begin
                seen_at = c;
                ifb.req = 1'b0;
                break;
            end
        end
        check("t6 reissue ack latency", seen_at, 5);
        check("t6 reissue if_rdata", ifb.rdata, 32'h2222_2222);
        ifb.req = 1'b0;
        tick();
        check("t6 idle after reissue", busy_b, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
